dm_pipe: RTL

Parametrised data memory for the pipelined MIPS core, replacing the single-cycle data memory. Adds request/ready handshake with configurable load latency, signed and unsigned sub-word loads, and address-exception detection. Also adds a post-reset clear sweep and a registered store-trace port for the testbench log. Sits in the MEM stage; the core stalls on ready=0 and takes results on rvalid.

---
 rtl/dm_pipe.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dm_pipe.sv
// MEM-stage data memory with a req/ready handshake, configurable load latency,
// sub-word loads and stores, address-exception flags and a registered store trace.
module dm_pipe #(
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 3072,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  op,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        trace_we,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY} state_t;

  logic [31:0]       mem [DEPTH];
  state_t            state, state_n;
  logic [IDX_W-1:0]  clr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              accept, done, fire;
  logic              is_half, is_byte, is_signed, misalign, out_of_range, err;
  logic [ADDR_W-1:0] widx;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       cur, merged, load_val;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              h_we, h_err, s_we, s_err;
  logic [31:0]       h_rdata, h_pc, h_addr, h_data;
  logic [31:0]       s_rdata, s_pc, s_addr, s_data;

  // Handshake: a request is taken on a rising edge where req && ready; the
  // result appears as a single-cycle rvalid pulse LATENCY-1 edges later.
  always_comb begin
    state_n = state;
    ready   = (state == ST_IDLE);
    accept  = req && ready;
    done    = 1'b0;
    case (state)
      ST_INIT: if (clr_ptr == IDX_W'(DEPTH - 1)) state_n = ST_IDLE;
      ST_IDLE: if (accept && (LATENCY > 1)) state_n = ST_BUSY;
      ST_BUSY: if (cnt == CNT_W'(1)) begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    is_half   = (op == 3'b001) || (op == 3'b011);
    is_byte   = (op == 3'b010) || (op == 3'b100);
    is_signed = (op == 3'b001) || (op == 3'b010);
    misalign  = is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00));
    widx      = addr[ADDR_W+1:2];
    // Splitting the word address keeps the range compare narrow.
    out_of_range = (addr[31:ADDR_W+2] != '0) ||
                   ({1'b0, widx} >= (ADDR_W+1)'(DEPTH));
    err       = misalign || out_of_range;
    idx       = widx[IDX_W-1:0];
    cur       = mem[idx];
    lane_b    = cur[8*addr[1:0] +: 8];
    lane_h    = cur[16*addr[1] +: 16];
    merged    = cur;
    load_val  = cur;
    if (is_byte) begin
      merged[8*addr[1:0] +: 8] = wdata[7:0];
      load_val = is_signed ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
    end else if (is_half) begin
      merged[16*addr[1] +: 16] = wdata[15:0];
      load_val = is_signed ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
    end else begin
      merged = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT)                     mem[clr_ptr] <= '0;
    else if (accept && we && !err && !reset)  mem[idx]     <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_ptr <= '0;
      cnt     <= '0;
      h_we    <= 1'b0;
      h_err   <= 1'b0;
      h_rdata <= '0;
      h_pc    <= '0;
      h_addr  <= '0;
      h_data  <= '0;
    end else begin
      if (state == ST_INIT) clr_ptr <= clr_ptr + 1'b1;
      if (accept)                cnt <= CNT_W'(LATENCY - 1);
      else if (state == ST_BUSY) cnt <= cnt - 1'b1;
      // Result is captured at acceptance so later stores cannot disturb it.
      if (accept) begin
        h_we    <= we;
        h_err   <= err;
        h_rdata <= (we || err) ? '0 : load_val;
        h_pc    <= pc;
        h_addr  <= addr;
        h_data  <= merged;
      end
    end
  end

  always_comb begin
    fire = (LATENCY == 1) ? accept : done;
    if (LATENCY == 1) begin
      s_we    = we;
      s_err   = err;
      s_rdata = (we || err) ? '0 : load_val;
      s_pc    = pc;
      s_addr  = addr;
      s_data  = merged;
    end else begin
      s_we    = h_we;
      s_err   = h_err;
      s_rdata = h_rdata;
      s_pc    = h_pc;
      s_addr  = h_addr;
      s_data  = h_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid     <= 1'b0;
      rdata      <= '0;
      exc_adel   <= 1'b0;
      exc_ades   <= 1'b0;
      trace_we   <= 1'b0;
      trace_pc   <= '0;
      trace_addr <= '0;
      trace_data <= '0;
    end else begin
      rvalid   <= fire;
      rdata    <= fire ? s_rdata : '0;
      exc_adel <= fire && s_err && !s_we;
      exc_ades <= fire && s_err && s_we;
      trace_we <= fire && s_we && !s_err;
      if (fire && s_we && !s_err) begin
        trace_pc   <= s_pc;
        trace_addr <= s_addr;
        trace_data <= s_data;
      end
    end
  end

endmodule
